// File: rtl/clk_en_hub_pkg.sv
// Shared types and constants for the cascaded clock-enable hub.
// Default ratios give 5 MHz, 1 MHz, 100 kHz ... 1 Hz enables from a 50 MHz clock.
package clk_hub_pkg;

    localparam int CLK_HZ    = 50_000_000;
    localparam int N_CH_DEF  = 8;
    localparam int CNT_W_DEF = 8;

    typedef logic [CNT_W_DEF-1:0] ratio_t;

    // Channel 0 is the least significant element.
    localparam logic [N_CH_DEF-1:0][CNT_W_DEF-1:0] DEF_RATIO = {
        8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd5, 8'd10
    };

    function automatic int unsigned ceil_half(input int unsigned r);
        return (r + 1) / 2;
    endfunction

endpackage

// File: rtl/clk_en_hub_if.sv
// Control/status bundle of the clock-enable hub: run enables, ratio writes, ticks and square waves.
interface clk_en_hub_if #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 8
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]  en_i;
    logic             sync_clr_i;
    logic             cfg_wr_i;
    logic [SEL_W-1:0] cfg_sel_i;
    logic [CNT_W-1:0] cfg_ratio_i;
    logic [N_CH-1:0]  cfg_pend_o;
    logic [N_CH-1:0]  tick_o;
    logic [N_CH-1:0]  sq_o;

    modport master (
        output en_i, sync_clr_i, cfg_wr_i, cfg_sel_i, cfg_ratio_i,
        input  cfg_pend_o, tick_o, sq_o
    );

    modport slave (
        input  en_i, sync_clr_i, cfg_wr_i, cfg_sel_i, cfg_ratio_i,
        output cfg_pend_o, tick_o, sq_o
    );
endinterface

// File: rtl/clk_en_stage.sv
// One divider channel: counter, active and pending ratio, square-wave register.
// t_o is the combinational terminal-count strobe that advances the next channel.
module clk_en_stage
    import clk_hub_pkg::*;
#(
    parameter int               CNT_W = 8,
    parameter logic [CNT_W-1:0] DEF   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             adv_i,
    input  logic             sync_clr_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_ratio_i,
    output logic             t_o,
    output logic             sq_o,
    output logic             pend_o
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_NORM = (DEF == '0) ? ONE : DEF;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic [CNT_W-1:0] pend_ratio_q, pend_ratio_d;
    logic             pend_q, pend_d;
    logic             sq_q, sq_d;
    logic [CNT_W-1:0] wr_norm;
    logic [CNT_W-1:0] half;
    logic             t;

    // Ratios are stored already normalised, so the terminal compare never sees 0.
    assign wr_norm = (wr_ratio_i == '0) ? ONE : wr_ratio_i;
    assign half    = CNT_W'(ceil_half(32'(ratio_q)));
    assign t       = en_i & adv_i & (cnt_q == ratio_q - ONE);

    always_comb begin
        cnt_d        = cnt_q;
        ratio_d      = ratio_q;
        pend_ratio_d = pend_ratio_q;
        pend_d       = pend_q;
        sq_d         = en_i & (ratio_q != ONE) & (cnt_q < half);

        if (sync_clr_i) begin
            cnt_d  = '0;
            pend_d = 1'b0;
            if (pend_q) ratio_d = pend_ratio_q;
            if (wr_i) begin
                ratio_d      = wr_norm;
                pend_ratio_d = wr_norm;
            end
        end else begin
            if (!en_i)      cnt_d = '0;
            else if (adv_i) cnt_d = t ? '0 : cnt_q + ONE;

            // Swap only at a period boundary (or while idle) so the running period is never cut short.
            if ((t || !en_i) && pend_q) begin
                ratio_d = pend_ratio_q;
                pend_d  = 1'b0;
            end
            // A write landing on the apply cycle stays queued behind the value just applied.
            if (wr_i) begin
                pend_ratio_d = wr_norm;
                pend_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            ratio_q      <= DEF_NORM;
            pend_ratio_q <= DEF_NORM;
            pend_q       <= 1'b0;
            sq_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            ratio_q      <= ratio_d;
            pend_ratio_q <= pend_ratio_d;
            pend_q       <= pend_d;
            sq_q         <= sq_d;
        end
    end

    assign t_o    = t;
    assign sq_o   = sq_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/clk_en_hub.sv
// Cascaded clock-enable generator: channel 0 divides clk, channel i divides channel i-1's tick.
// All ticks come out of one register stage so every channel's strobe is edge-coincident.
module clk_en_hub
    import clk_hub_pkg::*;
#(
    parameter int                              N_CH      = 8,
    parameter int                              CNT_W     = 8,
    parameter logic [N_CH-1:0][CNT_W-1:0]      DEF_RATIO = clk_hub_pkg::DEF_RATIO
) (
    input  logic         clk,
    input  logic         rst,
    clk_en_hub_if.slave  bus
);

    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0] adv;
    logic [N_CH-1:0] t;
    logic [N_CH-1:0] wr;
    logic [N_CH-1:0] sq;
    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] tick_q, tick_d;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        if (gi == 0) begin : g_src
            assign adv[gi] = 1'b1;
        end else begin : g_casc
            assign adv[gi] = t[gi-1];
        end

        // Selects beyond N_CH-1 match no channel and are dropped.
        assign wr[gi] = bus.cfg_wr_i & (bus.cfg_sel_i == SEL_W'(gi));

        clk_en_stage #(
            .CNT_W (CNT_W),
            .DEF   (DEF_RATIO[gi])
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .en_i       (bus.en_i[gi]),
            .adv_i      (adv[gi]),
            .sync_clr_i (bus.sync_clr_i),
            .wr_i       (wr[gi]),
            .wr_ratio_i (bus.cfg_ratio_i),
            .t_o        (t[gi]),
            .sq_o       (sq[gi]),
            .pend_o     (pend[gi])
        );
    end

    always_comb begin
        tick_d = t & ~{N_CH{bus.sync_clr_i}};
    end

    always_ff @(posedge clk) begin
        if (rst) tick_q <= '0;
        else     tick_q <= tick_d;
    end

    assign bus.tick_o     = tick_q;
    assign bus.sq_o       = sq;
    assign bus.cfg_pend_o = pend;

endmodule

// File: tb/tb_clk_en_hub.sv
// Directed bench for clk_en_hub: default cascade, runtime ratio changes, enable stall, sync clear, reset.
module tb_clk_en_hub;
    import clk_hub_pkg::*;

    localparam int N = 8;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clk_en_hub_if #(.N_CH(N), .CNT_W(W)) bus ();

    clk_en_hub #(.N_CH(N), .CNT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        ratio_t ratio;
        int     exp_period;
        int     exp_sq_hi;
    } vec_t;

    vec_t vecs[7];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cfg_write(input int sel, input int ratio, input bit sync);
        bus.cfg_wr_i    = 1'b1;
        bus.cfg_sel_i   = 3'(sel);
        bus.cfg_ratio_i = 8'(ratio);
        bus.sync_clr_i  = sync;
        step();
        bus.cfg_wr_i    = 1'b0;
        bus.sync_clr_i  = 1'b0;
    endtask

    // Steps until tick_o[ch] is seen; n = steps taken, -1 on timeout.
    task automatic wait_tick(input int ch, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.tick_o[ch] && n < budget);
        if (!bus.tick_o[ch]) n = -1;
    endtask

    task automatic measure(input int ch, input int budget, output int period, output int hi);
        int n;
        hi = 0;
        wait_tick(ch, budget, n);
        if (n < 0) begin
            period = -1;
            return;
        end
        period = 0;
        do begin
            step();
            period++;
            hi += int'(bus.sq_o[ch]);
        end while (!bus.tick_o[ch] && period < budget);
        if (!bus.tick_o[ch]) period = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first0, c0, c1, c2, c3, misalign, s0, s1, s2, n, n2, p, hi, bad, t0cnt;

        vecs[0] = '{8'd10, 10, 5};
        vecs[1] = '{8'd4,  4,  2};
        vecs[2] = '{8'd1,  1,  0};
        vecs[3] = '{8'd0,  1,  0};
        vecs[4] = '{8'd3,  3,  2};
        vecs[5] = '{8'd7,  7,  4};
        vecs[6] = '{8'd2,  2,  1};

        bus.en_i        = '1;
        bus.sync_clr_i  = 1'b0;
        bus.cfg_wr_i    = 1'b0;
        bus.cfg_sel_i   = '0;
        bus.cfg_ratio_i = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check("rst_tick", int'(bus.tick_o), 0);
        check("rst_sq", int'(bus.sq_o), 0);
        check("rst_pend", int'(bus.cfg_pend_o), 0);
        rst = 1'b0;

        // Default cascade over 2000 cycles
        first0 = -1; c0 = 0; c1 = 0; c2 = 0; c3 = 0; misalign = 0; s0 = 0; s1 = 0; s2 = 0;
        for (int k = 1; k <= 2000; k++) begin
            step();
            if (bus.tick_o[0]) begin
                c0++;
                if (first0 < 0) first0 = k;
            end
            if (bus.tick_o[1]) c1++;
            if (bus.tick_o[2]) c2++;
            if (bus.tick_o[3]) c3++;
            if (bus.tick_o[1] && !bus.tick_o[0]) misalign++;
            if (bus.tick_o[2] && !bus.tick_o[1]) misalign++;
            s0 += int'(bus.sq_o[0]);
            s1 += int'(bus.sq_o[1]);
            s2 += int'(bus.sq_o[2]);
        end
        check("def_first_tick0", first0, 10);
        check("def_ticks0", c0, 200);
        check("def_ticks1", c1, 40);
        check("def_ticks2", c2, 4);
        check("def_ticks3", c3, 0);
        check("def_misalign", misalign, 0);
        check("def_sq0_hi", s0, 1000);
        check("def_sq1_hi", s1, 1200);
        check("def_sq2_hi", s2, 1000);

        // Mid-count write: old period finishes, then the new one
        repeat (3) step();
        cfg_write(0, 4, 1'b0);
        check("wr_pend0", int'(bus.cfg_pend_o[0]), 1);
        wait_tick(0, 50, n);
        check("wr_old_tail", n, 6);
        check("wr_pend_clr", int'(bus.cfg_pend_o[0]), 0);
        measure(0, 50, p, hi);
        check("wr_new_period", p, 4);
        check("wr_new_sq_hi", hi, 2);

        // Table: ratio applied through sync clear, then period and duty
        foreach (vecs[i]) begin
            cfg_write(0, int'(vecs[i].ratio), 1'b1);
            check($sformatf("tbl%0d_pend", i), int'(bus.cfg_pend_o), 0);
            measure(0, 50, p, hi);
            check($sformatf("tbl%0d_r%0d_period", i, vecs[i].ratio), p, vecs[i].exp_period);
            check($sformatf("tbl%0d_r%0d_sq_hi", i, vecs[i].ratio), hi, vecs[i].exp_sq_hi);
        end

        // Enable stall on ch1
        cfg_write(0, 10, 1'b1);
        repeat (120) step();
        bus.en_i[1] = 1'b0;
        bad = 0; t0cnt = 0;
        repeat (37) begin
            step();
            if (bus.tick_o[7:1] != 7'd0) bad++;
            if (bus.tick_o[0]) t0cnt++;
        end
        check("stall_upper_ticks", bad, 0);
        check("stall_ch0_ticks", t0cnt, 3);
        check("stall_sq1", int'(bus.sq_o[1]), 0);
        bus.en_i[1] = 1'b1;
        wait_tick(1, 1000, n);
        check("stall_ch1_restart", n, 43);
        wait_tick(2, 1000, n2);
        check("stall_ch2_held", n2, 350);

        // Sync clear with a same-cycle write and another pending ratio
        cfg_write(2, 3, 1'b0);
        check("sync_pend_before", int'(bus.cfg_pend_o), 32'h04);
        wait_tick(0, 20, n);
        repeat (9) step();
        cfg_write(3, 2, 1'b1);
        check("sync_tick_cleared", int'(bus.tick_o), 0);
        check("sync_pend_after", int'(bus.cfg_pend_o), 0);
        wait_tick(2, 400, n);
        check("sync_ch2_first", n, 150);
        wait_tick(3, 400, n);
        check("sync_ch3_first", n, 150);

        // Reset mid-operation drops pending writes and restores defaults
        cfg_write(0, 3, 1'b0);
        cfg_write(5, 7, 1'b0);
        check("rst2_pend_before", int'(bus.cfg_pend_o), 32'h21);
        rst = 1'b1;
        step();
        check("rst2_tick", int'(bus.tick_o), 0);
        check("rst2_sq", int'(bus.sq_o), 0);
        check("rst2_pend", int'(bus.cfg_pend_o), 0);
        step();
        rst = 1'b0;
        wait_tick(0, 50, n);
        check("rst2_first_tick0", n, 10);
        wait_tick(0, 50, n);
        check("rst2_period0", n, 10);
        wait_tick(1, 100, n);
        check("rst2_first_tick1", n, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
